// File: rtl/if_mon_pkg.sv
// Shared definitions for the fetch-interface protocol monitor.
// Holds the counter and error index maps, the error vector type, and a
// helper that picks the lowest-indexed active error.
package if_mon_pkg;

   // Event counter indices (readout select values)
   localparam int unsigned CNT_BEAT        = 0;
   localparam int unsigned CNT_STALL       = 1;
   localparam int unsigned CNT_FLUSH       = 2;
   localparam int unsigned CNT_FLUSH_MISS  = 3;
   localparam int unsigned CNT_INV_INSTR   = 4;
   localparam int unsigned CNT_INV_PRED    = 5;
   localparam int unsigned CNT_RETURN      = 6;
   localparam int unsigned CNT_JUMPL       = 7;
   localparam int unsigned CNT_PART1       = 8;
   localparam int unsigned CNT_PART2       = 9;
   localparam int unsigned CNT_PART3       = 10;
   localparam int unsigned CNT_MISS        = 11;
   localparam int unsigned CNT_FLUSH_STALL = 12;
   localparam int unsigned CNT_WMARK       = 13;
   localparam int unsigned NUM_CNT         = 14;

   // Error bit indices
   localparam int unsigned ERR_MULTI = 0;
   localparam int unsigned ERR_STAB  = 1;
   localparam int unsigned ERR_PC    = 2;
   localparam int unsigned ERR_WDOG  = 3;
   localparam int unsigned NUM_ERR   = 4;

   typedef logic [NUM_ERR-1:0] err_vec_t;

   // Lowest set index wins when several errors fire together
   function automatic logic [1:0] first_err_idx(input err_vec_t e);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = int'(NUM_ERR) - 1; i >= 0; i--) begin
         if (e[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/if_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   clr_i  - synchronous clear (same effect as reset)
//   inc_i  - count one event this cycle
//   cnt_o  - current count
module if_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear has priority over any event in the same cycle
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/if_protocol_monitor.sv
// Passive checker for the instruction-fetch output handshake and restart rules.
// Flags violations with sticky error bits plus a first-error capture, and
// counts fetch events in saturating counters read through a select port.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   data_out, valid_o, ready_in - observed IF output beat and decode ready
//   invalid_prediction, invalid_instruction, is_return_in - restart sources
//   is_jumpl, must_flush        - call and high-tier flush indications
//   current_PC                  - fetch PC
//   Hit_cache, Miss, partial_access, partial_type - icache status
//   clear_i                     - synchronous clear of counters, errors, watermark
//   sel_i / cnt_o               - counter select and registered readout
//   err_o                       - sticky {watchdog, pc_bound, stability, multi_restart}
//   err_valid_o, err_code_o, err_pc_o - first-error pulse, index and PC
module if_protocol_monitor
   import if_mon_pkg::*;
#(
   parameter int unsigned LANES       = 2,
   parameter int unsigned PACKET_SIZE = 64,
   parameter int unsigned PC_BITS     = 32,
   parameter int unsigned PC_LIMIT    = 2048,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned STALL_LIMIT = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [LANES*PACKET_SIZE-1:0] data_out,
   input  logic                         valid_o,
   input  logic                         ready_in,
   input  logic                         invalid_prediction,
   input  logic                         invalid_instruction,
   input  logic                         is_return_in,
   input  logic                         is_jumpl,
   input  logic                         must_flush,
   input  logic [PC_BITS-1:0]           current_PC,
   input  logic                         Hit_cache,
   input  logic                         Miss,
   input  logic                         partial_access,
   input  logic [1:0]                   partial_type,
   input  logic                         clear_i,
   input  logic [3:0]                   sel_i,
   output logic [CNT_W-1:0]             cnt_o,
   output logic [3:0]                   err_o,
   output logic                         err_valid_o,
   output logic [1:0]                   err_code_o,
   output logic [PC_BITS-1:0]           err_pc_o
);

   localparam int unsigned DATA_W = LANES * PACKET_SIZE;
   // Wide enough to hold STALL_LIMIT+1 so the watchdog trip value is reachable
   localparam int unsigned RUN_W  = $clog2(STALL_LIMIT + 2);
   localparam logic [RUN_W-1:0] RUN_MAX  = {RUN_W{1'b1}};
   localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(STALL_LIMIT + 1);

   logic              stall;
   logic              beat;
   logic              first_err;
   err_vec_t          err_now;
   logic [NUM_CNT-2:0] ev;

   logic              prev_stall_q, prev_stall_d;
   logic              prev_flush_q, prev_flush_d;
   logic [DATA_W-1:0] prev_data_q,  prev_data_d;
   logic [RUN_W-1:0]  run_q,        run_d;
   logic [RUN_W-1:0]  wmark_q,      wmark_d;
   err_vec_t          err_q,        err_d;
   logic              err_vld_q,    err_vld_d;
   logic [1:0]        err_code_q,   err_code_d;
   logic [PC_BITS-1:0] err_pc_q,    err_pc_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;

   logic [NUM_CNT-2:0][CNT_W-1:0] cnt_ev;

   // Error detection, stall-run tracking and next-state computation
   always_comb begin
      stall = valid_o & ~ready_in;
      beat  = valid_o & ready_in;

      // Run resets on any non-stall or flush cycle, saturates otherwise
      run_d = run_q;
      if (!stall || must_flush)  run_d = '0;
      else if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);

      err_now = '0;
      err_now[ERR_MULTI] = (invalid_prediction  & invalid_instruction) |
                           (invalid_prediction  & is_return_in)        |
                           (invalid_instruction & is_return_in);
      // Held beat must stay valid and stable unless a flush touches either cycle
      err_now[ERR_STAB]  = prev_stall_q & ~prev_flush_q & ~must_flush &
                           (~valid_o | (data_out != prev_data_q));
      err_now[ERR_PC]    = 64'(current_PC) >= 64'(PC_LIMIT);
      err_now[ERR_WDOG]  = (run_d == RUN_TRIP) && (run_q != RUN_TRIP);

      first_err = (err_q == '0) && (err_now != '0);

      err_d      = err_q | err_now;
      err_vld_d  = first_err;
      err_code_d = first_err ? first_err_idx(err_now) : err_code_q;
      err_pc_d   = first_err ? current_PC : err_pc_q;

      wmark_d      = (run_d > wmark_q) ? run_d : wmark_q;
      prev_stall_d = stall;
      prev_flush_d = must_flush;
      prev_data_d  = data_out;

      if (sel_i == 4'(CNT_WMARK))     cnt_d = CNT_W'(wmark_q);
      else if (sel_i < 4'(CNT_WMARK)) cnt_d = cnt_ev[sel_i];
      else                            cnt_d = '0;
   end

   // Event strobes feeding the saturating counters
   always_comb begin
      ev                  = '0;
      ev[CNT_BEAT]        = beat;
      ev[CNT_STALL]       = stall;
      ev[CNT_FLUSH]       = must_flush;
      ev[CNT_FLUSH_MISS]  = must_flush & Miss;
      ev[CNT_INV_INSTR]   = invalid_instruction;
      ev[CNT_INV_PRED]    = invalid_prediction;
      ev[CNT_RETURN]      = is_return_in;
      ev[CNT_JUMPL]       = is_jumpl;
      ev[CNT_PART1]       = partial_access & Hit_cache & (partial_type == 2'd1);
      ev[CNT_PART2]       = partial_access & Hit_cache & (partial_type == 2'd2);
      ev[CNT_PART3]       = partial_access & Hit_cache & (partial_type == 2'd3);
      ev[CNT_MISS]        = Miss;
      ev[CNT_FLUSH_STALL] = must_flush & stall;
   end

   for (genvar gi = 0; gi < NUM_CNT - 1; gi++) begin : g_cnt
      if_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr_i (clear_i),
         .inc_i (ev[gi]),
         .cnt_o (cnt_ev[gi])
      );
   end

   // State registers; clear behaves like reset except for the readout path
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_stall_q <= 1'b0;
         prev_flush_q <= 1'b0;
         prev_data_q  <= '0;
         run_q        <= '0;
         wmark_q      <= '0;
         err_q        <= '0;
         err_vld_q    <= 1'b0;
         err_code_q   <= '0;
         err_pc_q     <= '0;
         cnt_q        <= '0;
      end else if (clear_i) begin
         prev_stall_q <= 1'b0;
         prev_flush_q <= 1'b0;
         prev_data_q  <= '0;
         run_q        <= '0;
         wmark_q      <= '0;
         err_q        <= '0;
         err_vld_q    <= 1'b0;
         err_code_q   <= '0;
         err_pc_q     <= '0;
         cnt_q        <= cnt_d;
      end else begin
         prev_stall_q <= prev_stall_d;
         prev_flush_q <= prev_flush_d;
         prev_data_q  <= prev_data_d;
         run_q        <= run_d;
         wmark_q      <= wmark_d;
         err_q        <= err_d;
         err_vld_q    <= err_vld_d;
         err_code_q   <= err_code_d;
         err_pc_q     <= err_pc_d;
         cnt_q        <= cnt_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign err_o       = err_q;
   assign err_valid_o = err_vld_q;
   assign err_code_o  = err_code_q;
   assign err_pc_o    = err_pc_q;

endmodule

// File: tb/tb_if_protocol_monitor.sv
// Self-checking bench for if_protocol_monitor (STALL_LIMIT=4, CNT_W=4).
// Per-cycle vector table replayed through a scoreboard queue, then a few
// hand-written sequences for watchdog, reset/clear priority and valid drop.
module tb_if_protocol_monitor;

   localparam int unsigned LANES = 2;
   localparam int unsigned PS    = 64;
   localparam int unsigned PCB   = 32;
   localparam int unsigned PCL   = 2048;
   localparam int unsigned CW    = 4;
   localparam int unsigned SL    = 4;
   localparam int unsigned DW    = LANES * PS;

   localparam int unsigned C_V    = 1;
   localparam int unsigned C_R    = 2;
   localparam int unsigned C_FL   = 4;
   localparam int unsigned C_IP   = 8;
   localparam int unsigned C_II   = 16;
   localparam int unsigned C_RET  = 32;
   localparam int unsigned C_JL   = 64;
   localparam int unsigned C_HIT  = 128;
   localparam int unsigned C_MISS = 256;
   localparam int unsigned C_PA   = 512;
   localparam int unsigned C_CLR  = 1024;

   logic           clk;
   logic           rst;
   logic [DW-1:0]  data_out;
   logic           valid_o, ready_in;
   logic           invalid_prediction, invalid_instruction, is_return_in;
   logic           is_jumpl, must_flush;
   logic [PCB-1:0] current_PC;
   logic           Hit_cache, Miss, partial_access;
   logic [1:0]     partial_type;
   logic           clear_i;
   logic [3:0]     sel_i;
   logic [CW-1:0]  cnt_o;
   logic [3:0]     err_o;
   logic           err_valid_o;
   logic [1:0]     err_code_o;
   logic [PCB-1:0] err_pc_o;

   if_protocol_monitor #(
      .LANES(LANES), .PACKET_SIZE(PS), .PC_BITS(PCB), .PC_LIMIT(PCL),
      .CNT_W(CW), .STALL_LIMIT(SL)
   ) dut (
      .clk(clk), .rst(rst), .data_out(data_out), .valid_o(valid_o),
      .ready_in(ready_in), .invalid_prediction(invalid_prediction),
      .invalid_instruction(invalid_instruction), .is_return_in(is_return_in),
      .is_jumpl(is_jumpl), .must_flush(must_flush), .current_PC(current_PC),
      .Hit_cache(Hit_cache), .Miss(Miss), .partial_access(partial_access),
      .partial_type(partial_type), .clear_i(clear_i), .sel_i(sel_i),
      .cnt_o(cnt_o), .err_o(err_o), .err_valid_o(err_valid_o),
      .err_code_o(err_code_o), .err_pc_o(err_pc_o)
   );

   typedef struct {
      int unsigned ctl;
      logic [7:0]  d;
      logic [31:0] pc;
      logic [1:0]  pt;
      logic [3:0]  sel;
      logic [3:0]  e_err;
      logic        e_vld;
      logic [1:0]  e_code;
      logic [31:0] e_pc;
      int          e_cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic add_full(input int unsigned ctl, input logic [7:0] d, input logic [31:0] pc,
                           input logic [1:0] pt, input logic [3:0] sel, input logic [3:0] e_err,
                           input logic e_vld, input logic [1:0] e_code, input logic [31:0] e_pc,
                           input int e_cnt);
      vec_t v;
      v.ctl = ctl; v.d = d; v.pc = pc; v.pt = pt; v.sel = sel;
      v.e_err = e_err; v.e_vld = e_vld; v.e_code = e_code; v.e_pc = e_pc; v.e_cnt = e_cnt;
      tbl.push_back(v);
   endtask

   task automatic add(input int unsigned ctl, input logic [7:0] d, input logic [3:0] sel,
                      input logic [3:0] e_err, input logic e_vld, input int e_cnt);
      add_full(ctl, d, 32'h0, 2'd0, sel, e_err, e_vld, 2'd0, 32'h0, e_cnt);
   endtask

   task automatic put(input int unsigned ctl, input logic [7:0] d, input logic [31:0] pc,
                      input logic [1:0] pt, input logic [3:0] sel);
      valid_o             = (ctl & C_V)    != 0;
      ready_in            = (ctl & C_R)    != 0;
      must_flush          = (ctl & C_FL)   != 0;
      invalid_prediction  = (ctl & C_IP)   != 0;
      invalid_instruction = (ctl & C_II)   != 0;
      is_return_in        = (ctl & C_RET)  != 0;
      is_jumpl            = (ctl & C_JL)   != 0;
      Hit_cache           = (ctl & C_HIT)  != 0;
      Miss                = (ctl & C_MISS) != 0;
      partial_access      = (ctl & C_PA)   != 0;
      clear_i             = (ctl & C_CLR)  != 0;
      data_out            = {(DW/8){d}};
      current_PC          = pc;
      partial_type        = pt;
      sel_i               = sel;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      rst = 1'b1;
      put(0, 8'h00, 32'h0, 2'd0, 4'd0);
      step();
      step();
      rst = 1'b0;

      chk("reset err_o", 64'(err_o), 64'h0);
      chk("reset err_valid_o", 64'(err_valid_o), 64'h0);
      chk("reset err_code_o", 64'(err_code_o), 64'h0);
      chk("reset err_pc_o", 64'(err_pc_o), 64'h0);
      chk("reset cnt_o", 64'(cnt_o), 64'h0);

      // 10 beats, then read counter 0
      for (int k = 0; k < 10; k++) add(C_V | C_R, 8'h00, 4'd0, 4'b0000, 1'b0, k);
      add(0, 8'h00, 4'd0, 4'b0000, 1'b0, 10);
      // stall 3 cycles, data changes on the 4th stalled cycle
      add(C_V, 8'h11, 4'd1, 4'b0000, 1'b0, 0);
      add(C_V, 8'h11, 4'd1, 4'b0000, 1'b0, 1);
      add(C_V, 8'h11, 4'd1, 4'b0000, 1'b0, 2);
      add_full(C_V, 8'h22, 32'h100, 2'd0, 4'd1, 4'b0010, 1'b1, 2'd1, 32'h100, 3);
      add(C_V | C_R, 8'h22, 4'd1, 4'b0010, 1'b0, 4);
      add(C_CLR, 8'h00, 4'd1, 4'b0000, 1'b0, 4);
      add(0, 8'h00, 4'd1, 4'b0000, 1'b0, 0);
      // same stall, flush in the data-change cycle
      add(C_V, 8'h33, 4'd2, 4'b0000, 1'b0, 0);
      add(C_V, 8'h33, 4'd2, 4'b0000, 1'b0, 0);
      add(C_V, 8'h33, 4'd2, 4'b0000, 1'b0, 0);
      add(C_V | C_FL, 8'h44, 4'd2, 4'b0000, 1'b0, 0);
      add(C_V | C_R, 8'h44, 4'd2, 4'b0000, 1'b0, 1);
      add(0, 8'h00, 4'd12, 4'b0000, 1'b0, 1);
      add(0, 8'h00, 4'd1, 4'b0000, 1'b0, 4);
      add(0, 8'h00, 4'd0, 4'b0000, 1'b0, 1);
      // double restart with PC at the limit
      add_full(C_IP | C_RET, 8'h00, 32'd2048, 2'd0, 4'd5, 4'b0101, 1'b1, 2'd0, 32'd2048, 0);
      add(0, 8'h00, 4'd5, 4'b0101, 1'b0, 1);
      add(C_II | C_JL, 8'h00, 4'd6, 4'b0101, 1'b0, 1);
      add(0, 8'h00, 4'd4, 4'b0101, 1'b0, 1);
      add(0, 8'h00, 4'd7, 4'b0101, 1'b0, 1);
      // partial access types, miss, flush&miss
      add_full(C_PA | C_HIT, 8'h00, 32'h0, 2'd1, 4'd8, 4'b0101, 1'b0, 2'd0, 32'h0, 0);
      add_full(C_PA | C_HIT, 8'h00, 32'h0, 2'd2, 4'd9, 4'b0101, 1'b0, 2'd0, 32'h0, 0);
      add_full(C_PA | C_HIT, 8'h00, 32'h0, 2'd3, 4'd8, 4'b0101, 1'b0, 2'd0, 32'h0, 1);
      add_full(C_PA, 8'h00, 32'h0, 2'd3, 4'd10, 4'b0101, 1'b0, 2'd0, 32'h0, 1);
      add(C_FL | C_MISS, 8'h00, 4'd10, 4'b0101, 1'b0, 1);
      add(0, 8'h00, 4'd3, 4'b0101, 1'b0, 1);
      add(0, 8'h00, 4'd11, 4'b0101, 1'b0, 1);
      add(0, 8'h00, 4'd2, 4'b0101, 1'b0, 2);
      add(0, 8'h00, 4'd9, 4'b0101, 1'b0, 1);
      add(C_CLR, 8'h00, 4'd0, 4'b0000, 1'b0, 1);
      add(0, 8'h00, 4'd0, 4'b0000, 1'b0, 0);
      // watchdog: 6 stalls, trips on the 5th
      for (int k = 0; k < 6; k++) begin
         if (k == 4) add_full(C_V, 8'h55, 32'h40, 2'd0, 4'd13, 4'b1000, 1'b1, 2'd3, 32'h40, 4);
         else        add(C_V, 8'h55, 4'd13, (k < 4) ? 4'b0000 : 4'b1000, 1'b0, k);
      end
      add(C_V | C_R, 8'h55, 4'd13, 4'b1000, 1'b0, 6);
      add(0, 8'h00, 4'd13, 4'b1000, 1'b0, 6);
      add(C_CLR, 8'h00, 4'd13, 4'b0000, 1'b0, 6);
      add(0, 8'h00, 4'd13, 4'b0000, 1'b0, 0);
      add(0, 8'h00, 4'd1, 4'b0000, 1'b0, 0);
      // miss counter saturation, unused selects, clear beats event
      for (int k = 0; k < 20; k++) add(C_MISS, 8'h00, 4'd11, 4'b0000, 1'b0, (k < 15) ? k : 15);
      add(0, 8'h00, 4'd11, 4'b0000, 1'b0, 15);
      add(0, 8'h00, 4'd15, 4'b0000, 1'b0, 0);
      add(0, 8'h00, 4'd14, 4'b0000, 1'b0, 0);
      add(C_CLR | C_MISS, 8'h00, 4'd11, 4'b0000, 1'b0, 15);
      add(0, 8'h00, 4'd11, 4'b0000, 1'b0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         put(tbl[i].ctl, tbl[i].d, tbl[i].pc, tbl[i].pt, tbl[i].sel);
         exp_q.push_back(tbl[i]);
         step();
         e = exp_q.pop_front();
         chk($sformatf("row%0d err_o", i), 64'(err_o), 64'(e.e_err));
         chk($sformatf("row%0d err_valid_o", i), 64'(err_valid_o), 64'(e.e_vld));
         if (e.e_vld) begin
            chk($sformatf("row%0d err_code_o", i), 64'(err_code_o), 64'(e.e_code));
            chk($sformatf("row%0d err_pc_o", i), 64'(err_pc_o), 64'(e.e_pc));
         end
         if (e.e_cnt >= 0) chk($sformatf("row%0d cnt_o", i), 64'(cnt_o), 64'(e.e_cnt));
      end

      // flush inside a long stall restarts the run: no watchdog, watermark 4
      for (int k = 0; k < 4; k++) begin put(C_V, 8'h66, 32'h0, 2'd0, 4'd13); step(); end
      put(C_V | C_FL, 8'h66, 32'h0, 2'd0, 4'd13); step();
      for (int k = 0; k < 4; k++) begin put(C_V, 8'h66, 32'h0, 2'd0, 4'd13); step(); end
      put(C_V | C_R, 8'h66, 32'h0, 2'd0, 4'd13); step();
      put(0, 8'h00, 32'h0, 2'd0, 4'd13); step();
      chk("flush_break err_o", 64'(err_o), 64'h0);
      chk("flush_break watermark", 64'(cnt_o), 64'd4);

      // exactly STALL_LIMIT+1 stalls trips the watchdog
      for (int k = 0; k < 5; k++) begin put(C_V, 8'h77, 32'h7FF, 2'd0, 4'd0); step(); end
      chk("wdog5 err_o", 64'(err_o), 64'h8);
      chk("wdog5 err_valid_o", 64'(err_valid_o), 64'h1);
      chk("wdog5 err_code_o", 64'(err_code_o), 64'd3);
      chk("wdog5 err_pc_o", 64'(err_pc_o), 64'h7FF);

      // reset together with clear: reset wins, every output returns to zero
      rst = 1'b1;
      put(C_CLR, 8'h00, 32'h0, 2'd0, 4'd13);
      step();
      rst = 1'b0;
      chk("rst_clr err_o", 64'(err_o), 64'h0);
      chk("rst_clr err_valid_o", 64'(err_valid_o), 64'h0);
      chk("rst_clr err_code_o", 64'(err_code_o), 64'h0);
      chk("rst_clr err_pc_o", 64'(err_pc_o), 64'h0);
      chk("rst_clr cnt_o", 64'(cnt_o), 64'h0);

      // stalled beat withdrawn (valid drops) is a stability error
      put(C_V, 8'h88, 32'h0, 2'd0, 4'd1); step();
      put(0, 8'h00, 32'h0, 2'd0, 4'd1); step();
      chk("valid_drop err_o", 64'(err_o), 64'h2);
      chk("valid_drop err_valid_o", 64'(err_valid_o), 64'h1);
      chk("valid_drop err_code_o", 64'(err_code_o), 64'd1);
      chk("valid_drop stall count", 64'(cnt_o), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
